// File: rtl/ff_edge_monitor.sv
// ---------------------------------------------------------------------------
// ff_edge_monitor
//
// Purpose:
//   Watches the true/complement outputs of an upstream negedge D flop. It
//   validates them (q must differ from qn), tracks the validated level, counts
//   rising and falling transitions and invalid samples, and latches into a
//   FAULT state after ERR_LIMIT consecutive invalid samples.
//
//   Pipeline: q/qn are registered into q_r/qn_r on every rising edge. The
//   decision logic looks only at q_r/qn_r, so an input change captured at
//   edge k is visible on the outputs after edge k+1.
//
// Parameters:
//   CNT_W      width of each event counter (saturating)
//   ERR_LIMIT  consecutive invalid samples that force FAULT (1..15)
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     synchronous active-low reset, highest priority
//   q, qn       true/complement outputs of the upstream flop
//   clr         synchronous clear of counters, fault and state
//   level       last validated value of q
//   edge_pulse  one-cycle strobe on each validated transition
//   rise_cnt    validated 0->1 transitions
//   fall_cnt    validated 1->0 transitions
//   viol_cnt    invalid samples (q == qn)
//   fault       high while the FSM is in FAULT
//   state       FSM state: IDLE=0, TRACK_LO=1, TRACK_HI=2, FAULT=3
// ---------------------------------------------------------------------------
module ff_edge_monitor #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             q,
    input  logic             qn,
    input  logic             clr,
    output logic             level,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             fault,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK_LO = 2'd1,
        TRACK_HI = 2'd2,
        FAULT    = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = ERR_LIMIT[3:0];

    state_t     state_q;
    logic       q_r;
    logic       qn_r;
    logic [3:0] bad_run;
    logic [3:0] bad_run_inc;
    logic       sample_ok;

    // The q_r/qn_r reset values (0/1) are placeholders, not a real capture.
    // primed stays low until the first post-reset capture so the FSM never
    // makes a decision on them. clr does not touch it, because the sampling
    // registers keep capturing while clr is high.
    logic       primed;

    assign state       = state_q;
    assign sample_ok   = (q_r != qn_r);
    assign bad_run_inc = (bad_run == 4'hF) ? bad_run : bad_run + 4'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_r        <= 1'b0;
            qn_r       <= 1'b1;
            primed     <= 1'b0;
            state_q    <= IDLE;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
            fault      <= 1'b0;
            rise_cnt   <= '0;
            fall_cnt   <= '0;
            viol_cnt   <= '0;
            bad_run    <= 4'd0;
        end else begin
            q_r        <= q;
            qn_r       <= qn;
            primed     <= 1'b1;
            edge_pulse <= 1'b0;

            if (clr) begin
                // Whatever the current sample would have done is discarded.
                state_q  <= IDLE;
                level    <= 1'b0;
                fault    <= 1'b0;
                rise_cnt <= '0;
                fall_cnt <= '0;
                viol_cnt <= '0;
                bad_run  <= 4'd0;
            end else if (primed && (state_q != FAULT)) begin
                if (sample_ok) begin
                    bad_run <= 4'd0;
                    case (state_q)
                        IDLE: begin
                            level   <= q_r;
                            state_q <= q_r ? TRACK_HI : TRACK_LO;
                        end
                        TRACK_LO: begin
                            if (q_r) begin
                                state_q    <= TRACK_HI;
                                level      <= 1'b1;
                                edge_pulse <= 1'b1;
                                if (rise_cnt != '1) rise_cnt <= rise_cnt + 1'b1;
                            end
                        end
                        TRACK_HI: begin
                            if (!q_r) begin
                                state_q    <= TRACK_LO;
                                level      <= 1'b0;
                                edge_pulse <= 1'b1;
                                if (fall_cnt != '1) fall_cnt <= fall_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    // Invalid sample: count it, hold level/state, and fault
                    // on the very edge the run length hits the limit.
                    bad_run <= bad_run_inc;
                    if (viol_cnt != '1) viol_cnt <= viol_cnt + 1'b1;
                    if (bad_run_inc >= LIMIT) begin
                        state_q <= FAULT;
                        fault   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ff_edge_monitor.sv
// ---------------------------------------------------------------------------
// tb_ff_edge_monitor
//
// Two instances: dut (CNT_W=8, ERR_LIMIT=3) for the main scenarios and dut2
// (CNT_W=2) for counter saturation. Drivers apply inputs just after a falling
// edge and push the hand-computed output snapshot expected at a given cycle
// into exp_q. The monitor runs on every falling edge, pops entries due at
// that cycle and compares them against the live outputs.
// ---------------------------------------------------------------------------
module tb_ff_edge_monitor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       q, qn, clr;
  logic       level, edge_pulse, fault;
  logic [7:0] rise_cnt, fall_cnt, viol_cnt;
  logic [1:0] state;

  logic       q2, qn2, clr2;
  logic       level2, edge_pulse2, fault2;
  logic [1:0] rise_cnt2, fall_cnt2, viol_cnt2;
  logic [1:0] state2;

  ff_edge_monitor #(.CNT_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .reset_n(reset_n), .q(q), .qn(qn), .clr(clr),
    .level(level), .edge_pulse(edge_pulse),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .viol_cnt(viol_cnt),
    .fault(fault), .state(state)
  );

  ff_edge_monitor #(.CNT_W(2), .ERR_LIMIT(3)) dut2 (
    .clk(clk), .reset_n(reset_n), .q(q2), .qn(qn2), .clr(clr2),
    .level(level2), .edge_pulse(edge_pulse2),
    .rise_cnt(rise_cnt2), .fall_cnt(fall_cnt2), .viol_cnt(viol_cnt2),
    .fault(fault2), .state(state2)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int         at;
    int         which;
    logic [1:0] st;
    logic       lv;
    logic       ep;
    logic       ft;
    logic [7:0] r;
    logic [7:0] f;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   ep_cnt = 0;

  task automatic ex(input int d, input int which, input logic [1:0] st,
                    input logic lv, input logic ep, input logic ft,
                    input logic [7:0] r, input logic [7:0] f,
                    input logic [7:0] v);
    exp_t e;
    e.at = cyc + d; e.which = which; e.st = st; e.lv = lv; e.ep = ep;
    e.ft = ft; e.r = r; e.f = f; e.v = v;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic [1:0] g_st;
  logic       g_lv, g_ep, g_ft;
  logic [7:0] g_r, g_f, g_v;

  always @(negedge clk) begin
    if (edge_pulse) ep_cnt++;
  end

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == cyc) begin
        if (exp_q[i].which == 0) begin
          g_st = state; g_lv = level; g_ep = edge_pulse; g_ft = fault;
          g_r = rise_cnt; g_f = fall_cnt; g_v = viol_cnt;
        end else begin
          g_st = state2; g_lv = level2; g_ep = edge_pulse2; g_ft = fault2;
          g_r = {6'd0, rise_cnt2}; g_f = {6'd0, fall_cnt2};
          g_v = {6'd0, viol_cnt2};
        end
        checks++;
        if (g_st === exp_q[i].st && g_lv === exp_q[i].lv &&
            g_ep === exp_q[i].ep && g_ft === exp_q[i].ft &&
            g_r === exp_q[i].r && g_f === exp_q[i].f && g_v === exp_q[i].v) begin
          passes++;
        end else begin
          fails++;
          $display("FAIL snapshot dut%0d cyc %0d: got st=%0d lv=%b ep=%b ft=%b r=%0d f=%0d v=%0d, want st=%0d lv=%b ep=%b ft=%b r=%0d f=%0d v=%0d",
                   exp_q[i].which, cyc, g_st, g_lv, g_ep, g_ft, g_r, g_f, g_v,
                   exp_q[i].st, exp_q[i].lv, exp_q[i].ep, exp_q[i].ft,
                   exp_q[i].r, exp_q[i].f, exp_q[i].v);
        end
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input logic a, input logic b);
    q  = a;
    qn = b;
  endtask

  task automatic drv2(input logic a, input logic b);
    q2  = a;
    qn2 = b;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; clr = 1'b0; clr2 = 1'b0;
    drv(1'b1, 1'b0);
    drv2(1'b0, 1'b1);

    tk(1);
    ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    ex(1, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    tk(1);
    reset_n = 1'b1;
    ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    ex(2, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    ex(3, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    ex(2, 1, 2'd1, 0, 0, 0, 0, 0, 0);
    tk(3);

    drv(1'b0, 1'b1); clr = 1'b1;
    ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    tk(1);
    clr = 1'b0;
    ex(1, 0, 2'd1, 0, 0, 0, 0, 0, 0);
    tk(1);

    checks++;
    if (ep_cnt == 0) passes++;
    else begin
      fails++;
      $display("FAIL edge_pulse asserted %0d times before toggle test", ep_cnt);
    end

    drv(1'b1, 1'b0);
    ex(1, 0, 2'd1, 0, 0, 0, 0, 0, 0);
    ex(2, 0, 2'd2, 1, 1, 0, 1, 0, 0);
    ex(3, 0, 2'd2, 1, 0, 0, 1, 0, 0);
    ex(4, 0, 2'd2, 1, 0, 0, 1, 0, 0);
    tk(4);
    drv(1'b0, 1'b1);
    ex(1, 0, 2'd2, 1, 0, 0, 1, 0, 0);
    ex(2, 0, 2'd1, 0, 1, 0, 1, 1, 0);
    ex(3, 0, 2'd1, 0, 0, 0, 1, 1, 0);
    ex(4, 0, 2'd1, 0, 0, 0, 1, 1, 0);
    tk(4);

    checks++;
    if (ep_cnt == 2) passes++;
    else begin
      fails++;
      $display("FAIL edge_pulse strobes after toggle: got %0d want 2", ep_cnt);
    end

    ex(2, 0, 2'd1, 0, 0, 0, 1, 1, 1);
    ex(3, 0, 2'd1, 0, 0, 0, 1, 1, 2);
    ex(4, 0, 2'd1, 0, 0, 0, 1, 1, 2);
    ex(5, 0, 2'd1, 0, 0, 0, 1, 1, 3);
    ex(6, 0, 2'd1, 0, 0, 0, 1, 1, 4);
    ex(7, 0, 2'd1, 0, 0, 0, 1, 1, 4);
    drv(1'b1, 1'b1); tk(2);
    drv(1'b0, 1'b1); tk(1);
    drv(1'b1, 1'b1); tk(2);
    drv(1'b0, 1'b1); tk(2);

    ex(2,  0, 2'd1, 0, 0, 0, 1, 1, 5);
    ex(3,  0, 2'd1, 0, 0, 0, 1, 1, 6);
    ex(4,  0, 2'd3, 0, 0, 1, 1, 1, 7);
    ex(8,  0, 2'd3, 0, 0, 1, 1, 1, 7);
    ex(11, 0, 2'd3, 0, 0, 1, 1, 1, 7);
    drv(1'b0, 1'b0); tk(3);
    drv(1'b1, 1'b0); tk(2);
    drv(1'b0, 1'b1); tk(2);
    drv(1'b1, 1'b1); tk(2);
    drv(1'b1, 1'b0); tk(2);
    clr = 1'b1;
    ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    tk(1);
    clr = 1'b0;
    ex(1, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    tk(1);

    ex(2,  1, 2'd2, 1, 1, 0, 1, 0, 0);
    ex(10, 1, 2'd2, 1, 1, 0, 3, 2, 0);
    ex(12, 1, 2'd1, 0, 1, 0, 3, 3, 0);
    ex(14, 1, 2'd2, 1, 1, 0, 3, 3, 0);
    ex(18, 1, 2'd2, 1, 1, 0, 3, 3, 0);
    ex(20, 1, 2'd1, 0, 1, 0, 3, 3, 0);
    for (int i = 0; i < 5; i++) begin
      drv2(1'b1, 1'b0); tk(2);
      drv2(1'b0, 1'b1); tk(2);
    end

    drv2(1'b1, 1'b0); tk(1);
    clr2 = 1'b1;
    ex(1, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    tk(1);
    clr2 = 1'b0;
    ex(1, 1, 2'd2, 1, 0, 0, 0, 0, 0);
    tk(1);

    ex(2, 0, 2'd2, 1, 0, 0, 0, 0, 1);
    ex(4, 0, 2'd3, 1, 0, 1, 0, 0, 3);
    drv(1'b0, 1'b0); tk(3);
    drv(1'b0, 1'b1); tk(1);
    reset_n = 1'b0; clr = 1'b1;
    ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    ex(1, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    tk(1);
    reset_n = 1'b1; clr = 1'b0;
    ex(1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    ex(2, 0, 2'd1, 0, 0, 0, 0, 0, 0);
    ex(2, 1, 2'd2, 1, 0, 0, 0, 0, 0);
    tk(4);

    checks++;
    if (state === 2'd1 && fault === 1'b0) passes++;
    else begin
      fails++;
      $display("FAIL post-reset dut: state=%0d fault=%b", state, fault);
    end

    checks++;
    if (rise_cnt === 8'd0 && fall_cnt === 8'd0 && viol_cnt === 8'd0) passes++;
    else begin
      fails++;
      $display("FAIL post-reset dut counters: r=%0d f=%0d v=%0d",
               rise_cnt, fall_cnt, viol_cnt);
    end

    checks++;
    if (state2 === 2'd2 && rise_cnt2 === 2'd0) passes++;
    else begin
      fails++;
      $display("FAIL post-reset dut2: state=%0d r=%0d", state2, rise_cnt2);
    end

    while (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL unserviced dut%0d: due cyc %0d, now cyc %0d",
               exp_q[0].which, exp_q[0].at, cyc);
      void'(exp_q.pop_front());
    end

    if (fails == 0) $display("PASS: %0d/%0d checks passed", passes, checks);
    else $display("FAIL: %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
